// File: rtl/fetch_decode_buffer.sv
// Two-entry in-order skid buffer between instruction fetch and decode.
// Head is presented to decode; flush discards everything buffered.
module fetch_decode_buffer #(
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fd_in_valid,
   input  logic [31:0] fd_in_instr,
   input  logic [31:0] fd_in_pc_plus4,
   output logic        fd_out_ready,
   input  logic        fd_in_flush,
   input  logic        fd_in_decode_ready,
   output logic        fd_out_valid,
   output logic [31:0] fd_out_instr,
   output logic [31:0] fd_out_pc_plus4,
   output logic [31:0] fd_out_pc,
   output logic [1:0]  fd_out_count
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned CW   = 2;

   logic [CW-1:0]   count_q, count_d;
   logic [XLEN-1:0] head_instr_q, head_instr_d;
   logic [XLEN-1:0] head_pc4_q,   head_pc4_d;
   logic [XLEN-1:0] tail_instr_q, tail_instr_d;
   logic [XLEN-1:0] tail_pc4_q,   tail_pc4_d;
   logic            push, pop;

   // Handshakes depend only on state, reset and flush.
   assign fd_out_ready    = rst_n && !fd_in_flush && (count_q != CW'(2));
   assign fd_out_valid    = (count_q != CW'(0)) && !fd_in_flush;
   assign push            = fd_in_valid && fd_out_ready;
   assign pop             = fd_out_valid && fd_in_decode_ready;
   assign fd_out_instr    = fd_out_valid ? head_instr_q : NOP_INSTR;
   assign fd_out_pc_plus4 = fd_out_valid ? head_pc4_q : '0;
   assign fd_out_pc       = fd_out_valid ? (head_pc4_q - XLEN'(4)) : '0;
   assign fd_out_count    = count_q;

   always_comb begin
      count_d      = count_q;
      head_instr_d = head_instr_q;
      head_pc4_d   = head_pc4_q;
      tail_instr_d = tail_instr_q;
      tail_pc4_d   = tail_pc4_q;
      if (fd_in_flush) begin
         count_d = '0;
      end else if (push && pop) begin
         // Only reachable at count 1: new entry replaces the consumed head.
         head_instr_d = fd_in_instr;
         head_pc4_d   = fd_in_pc_plus4;
      end else if (push) begin
         if (count_q == CW'(0)) begin
            head_instr_d = fd_in_instr;
            head_pc4_d   = fd_in_pc_plus4;
         end else begin
            tail_instr_d = fd_in_instr;
            tail_pc4_d   = fd_in_pc_plus4;
         end
         count_d = count_q + CW'(1);
      end else if (pop) begin
         if (count_q == CW'(2)) begin
            head_instr_d = tail_instr_q;
            head_pc4_d   = tail_pc4_q;
         end
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q      <= '0;
         head_instr_q <= '0;
         head_pc4_q   <= '0;
         tail_instr_q <= '0;
         tail_pc4_q   <= '0;
      end else begin
         count_q      <= count_d;
         head_instr_q <= head_instr_d;
         head_pc4_q   <= head_pc4_d;
         tail_instr_q <= tail_instr_d;
         tail_pc4_q   <= tail_pc4_d;
      end
   end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed vector table plus randomized traffic checked against a queue model.
module tb_fetch_decode_buffer;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst_n, fd_in_valid, fd_in_flush, fd_in_decode_ready;
   logic [31:0] fd_in_instr, fd_in_pc_plus4;
   logic        fd_out_ready, fd_out_valid;
   logic [31:0] fd_out_instr, fd_out_pc_plus4, fd_out_pc;
   logic [1:0]  fd_out_count;

   int tests = 0;
   int fails = 0;

   fetch_decode_buffer #(.NOP_INSTR(NOP)) dut (
      .clk(clk), .rst_n(rst_n),
      .fd_in_valid(fd_in_valid), .fd_in_instr(fd_in_instr),
      .fd_in_pc_plus4(fd_in_pc_plus4), .fd_out_ready(fd_out_ready),
      .fd_in_flush(fd_in_flush), .fd_in_decode_ready(fd_in_decode_ready),
      .fd_out_valid(fd_out_valid), .fd_out_instr(fd_out_instr),
      .fd_out_pc_plus4(fd_out_pc_plus4), .fd_out_pc(fd_out_pc),
      .fd_out_count(fd_out_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n, flush, valid, dec;
      logic [31:0] instr, pc4;
      logic        e_valid, e_ready;
      logic [31:0] e_instr, e_pc4, e_pc;
      logic [1:0]  e_count;
   } vec_t;

   typedef struct {
      logic [31:0] instr, pc4;
   } entry_t;

   vec_t   vt[$];
   entry_t mq[$];

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0d: got %h want %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic f, input logic v, input logic d,
                        input logic [31:0] i, input logic [31:0] p);
      rst_n = r; fd_in_flush = f; fd_in_valid = v; fd_in_decode_ready = d;
      fd_in_instr = i; fd_in_pc_plus4 = p;
   endtask

   task automatic addv(input logic r, input logic f, input logic v, input logic d,
                       input logic [31:0] i, input logic [31:0] p,
                       input logic ev, input logic er, input logic [31:0] ei,
                       input logic [31:0] ep4, input logic [31:0] epc, input logic [1:0] ec);
      vec_t x;
      x.rst_n = r; x.flush = f; x.valid = v; x.dec = d; x.instr = i; x.pc4 = p;
      x.e_valid = ev; x.e_ready = er; x.e_instr = ei; x.e_pc4 = ep4; x.e_pc = epc; x.e_count = ec;
      vt.push_back(x);
   endtask

   task automatic check_all(input int idx, input logic ev, input logic er, input logic [31:0] ei,
                            input logic [31:0] ep4, input logic [31:0] epc, input logic [1:0] ec);
      chk("valid", idx, 32'(fd_out_valid), 32'(ev));
      chk("ready", idx, 32'(fd_out_ready), 32'(er));
      chk("instr", idx, fd_out_instr, ei);
      chk("pc_plus4", idx, fd_out_pc_plus4, ep4);
      chk("pc", idx, fd_out_pc, epc);
      chk("count", idx, 32'(fd_out_count), 32'(ec));
   endtask

   initial begin
      // rst flush valid dec instr pc4 | valid ready instr pc4 pc count
      addv(0,0,0,0, 32'h0, 32'h0,                 0,0, NOP, 0, 0, 0);
      addv(1,0,1,1, 32'h00500093, 32'h4,          0,1, NOP, 0, 0, 0);
      addv(1,0,0,1, 32'h0, 32'h0,                 1,1, 32'h00500093, 32'h4, 32'h0, 1);
      addv(1,0,1,0, 32'h00100113, 32'h4,          0,1, NOP, 0, 0, 0);
      addv(1,0,1,0, 32'h00200193, 32'h8,          1,1, 32'h00100113, 32'h4, 32'h0, 1);
      addv(1,0,1,0, 32'hBAD0BAD0, 32'hC,          1,0, 32'h00100113, 32'h4, 32'h0, 2);
      addv(1,0,0,1, 32'h0, 32'h0,                 1,0, 32'h00100113, 32'h4, 32'h0, 2);
      addv(1,0,0,1, 32'h0, 32'h0,                 1,1, 32'h00200193, 32'h8, 32'h4, 1);
      addv(1,0,1,0, 32'h00300213, 32'h10,         0,1, NOP, 0, 0, 0);
      addv(1,0,1,1, 32'h00400293, 32'h14,         1,1, 32'h00300213, 32'h10, 32'hC, 1);
      addv(1,0,0,0, 32'h0, 32'h0,                 1,1, 32'h00400293, 32'h14, 32'h10, 1);
      addv(1,0,1,0, 32'h00000011, 32'h18,         1,1, 32'h00400293, 32'h14, 32'h10, 1);
      addv(1,1,1,1, 32'h00000022, 32'h1C,         0,0, NOP, 0, 0, 2);
      addv(1,0,0,0, 32'h0, 32'h0,                 0,1, NOP, 0, 0, 0);
      addv(1,0,1,0, 32'h000000A1, 32'h20,         0,1, NOP, 0, 0, 0);
      addv(1,0,1,0, 32'h000000A2, 32'h24,         1,1, 32'h000000A1, 32'h20, 32'h1C, 1);
      addv(0,0,1,1, 32'h000000A3, 32'h28,         1,0, 32'h000000A1, 32'h20, 32'h1C, 2);
      addv(1,0,0,1, 32'h0, 32'h0,                 0,1, NOP, 0, 0, 0);
      addv(1,0,1,1, 32'hDEADBEEF, 32'h0,          0,1, NOP, 0, 0, 0);
      addv(1,0,0,1, 32'h0, 32'h0,                 1,1, 32'hDEADBEEF, 32'h0, 32'hFFFFFFFC, 1);
      addv(1,0,0,1, 32'h0, 32'h0,                 0,1, NOP, 0, 0, 0);

      drive(0,0,0,0,0,0);
      repeat (2) @(posedge clk);

      foreach (vt[k]) begin
         @(negedge clk);
         drive(vt[k].rst_n, vt[k].flush, vt[k].valid, vt[k].dec, vt[k].instr, vt[k].pc4);
         #1;
         check_all(k, vt[k].e_valid, vt[k].e_ready, vt[k].e_instr, vt[k].e_pc4, vt[k].e_pc, vt[k].e_count);
         @(posedge clk);
      end

      // Randomized traffic; buffer is empty after the last table row.
      mq.delete();
      for (int c = 0; c < 3000; c++) begin
         logic r, f, v, d, ev, er, pu, po;
         logic [31:0] i, p, ei, ep4, epc;
         entry_t e;
         @(negedge clk);
         r = ($urandom_range(0, 49) != 0);
         f = ($urandom_range(0, 9) == 0);
         v = ($urandom_range(0, 9) < 7);
         d = ($urandom_range(0, 9) < 6);
         i = $urandom;
         p = $urandom;
         drive(r, f, v, d, i, p);
         ev  = (mq.size() > 0) && !f;
         er  = r && !f && (mq.size() < 2);
         ei  = ev ? mq[0].instr : NOP;
         ep4 = ev ? mq[0].pc4 : 32'h0;
         epc = ev ? mq[0].pc4 - 32'd4 : 32'h0;
         #1;
         check_all(1000 + c, ev, er, ei, ep4, epc, 2'(mq.size()));
         @(posedge clk);
         pu = v && er;
         po = ev && d;
         if (!r || f) begin
            mq.delete();
         end else begin
            if (po) void'(mq.pop_front());
            if (pu) begin
               e.instr = i; e.pc4 = p;
               mq.push_back(e);
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
